br_pred: RTL and testbench
==========================

Name: br_pred

Overview:
- Dynamic branch predictor that sits directly upstream of the execute-stage branch ALU.
- It is indexed by the fetch PC and supplies the registered pr_taken bit and predicted next-PC that travel with the instruction into execute.
- It consumes the execute-stage resolution: actual outcome = pr_taken XOR pr_miss, for conditional branches (opcode 1100011).
- It trains a table of 2-bit saturating counters and keeps branch and mispredict statistics.

Parameters:
- BHT_ENTRIES, 64, number of 2-bit counters; power of two, 4..1024.
- IDX_W, $clog2(BHT_ENTRIES), index width; the index is pc[IDX_W+1:2].
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- if_valid  in  1  fetch stage holds a valid instruction.
- if_pc  in  64  fetch PC.
- if_ir  in  32  fetched instruction.
- stall  in  1  pipeline stall; holds all prediction state.
- flush  in  1  pipeline flush (mispredict or JALR redirect).
- pr_taken  out  1  registered prediction for the instruction now in decode.
- pr_addr  out  64  registered predicted next PC for the same instruction.
- pr_valid  out  1  pr_taken/pr_addr refer to a valid conditional branch.
- ex_valid  in  1  execute stage holds a valid, non-stalled instruction.
- ex_pc  in  64  execute PC.
- ex_ir  in  32  execute instruction.
- ex_pr_taken  in  1  prediction that travelled with the execute instruction.
- ex_pr_miss  in  1  mispredict flag from the branch ALU.
- br_cnt  out  CNT_W  resolved conditional branches.
- miss_cnt  out  CNT_W  mispredicted conditional branches.

Behaviour:
- Reset, asynchronous on rst_n low:
  - All counters = 2'b01 (weakly not-taken).
  - pr_taken = 0, pr_valid = 0, pr_addr = 0.
  - br_cnt = 0, miss_cnt = 0.
  - Deasserting reset mid-operation needs no further sequencing; the block is ready in the first clk edge after rst_n rises.
- Lookup, combinational in the fetch cycle, registered at the clk edge:
  - f_br = if_valid && if_ir[6:0] == 7'b1100011.
  - f_idx = if_pc[IDX_W+1:2].
  - taken = f_br && counter[f_idx][1].
  - Offset = sign-extended B-immediate {ir[31], ir[7], ir[30:25], ir[11:8], 0}.
  - Target = taken ? if_pc + offset : if_pc + 4; the add wraps modulo 2^64.
  - At the edge: if !stall, then pr_valid <= f_br && !flush, pr_taken <= taken && !flush, pr_addr <= target.
  - Latency is 1 cycle, fetch to pr_*.
- Stall and flush:
  - stall = 1: pr_* hold their values, no counter update, no statistics increment.
  - flush = 1 with stall = 0: pr_valid and pr_taken clear; pr_addr is don't-care.
  - Simultaneous stall and flush: stall wins and the outputs hold. The pipeline re-asserts flush.
- Update, one clk edge after resolution:
  - e_br = ex_valid && !stall && ex_ir[6:0] == 7'b1100011.
  - actual = ex_pr_taken ^ ex_pr_miss.
  - e_idx = ex_pc[IDX_W+1:2].
  - If e_br: counter[e_idx] increments when actual = 1 (saturates at 11) and decrements when actual = 0 (saturates at 00).
  - Non-branch or invalid execute instructions never modify any counter.
- Same-index bypass: if e_br and e_idx == f_idx in the same cycle, the lookup uses the post-update counter value.
- Statistics:
  - br_cnt += 1 on every e_br; miss_cnt += 1 on e_br && ex_pr_miss.
  - Both counters saturate at all-ones and never wrap.
- Aliasing: PCs differing only above bit IDX_W+1 share a counter by design; this is not an error.

Test Plan:
- Reset check: drive rst_n low mid-run with clk stopped -> pr_taken = 0, pr_valid = 0, br_cnt = 0 immediately. A fetch of a BEQ at pc 0x1000 after release -> pr_taken = 0, pr_addr = 0x1004.
- Training: resolve BEQ at pc 0x1000 (ir imm = +16) as taken twice (ex_pr_taken = 0, ex_pr_miss = 1, then ex_pr_taken = 0, ex_pr_miss = 1) -> counter goes 01 -> 10 -> 11. The next fetch gives pr_taken = 1, pr_addr = 0x1010. Two not-taken resolutions -> 01, pr_taken = 0.
- Saturation and negative offset: 5 taken updates on BNE at pc 0x2000 with imm = -8 -> counter stays 11, pr_addr = 0x1FF8. miss_cnt increments only on mispredicted resolutions.
- Bypass: fetch BLT at pc 0x3000 in the same cycle as a taken update to pc 0x3000 with counter at 01 -> pr_taken = 1 on the next cycle.
- Stall and flush: assert stall for 3 cycles with updates pending -> pr_* and counters unchanged, br_cnt unchanged. Assert flush with a branch in fetch -> pr_valid = 0 next cycle. Assert stall and flush together -> outputs hold.
- Non-branch filter: fetch ADDI with if_valid = 1 -> pr_valid = 0, pr_addr = pc + 4. Execute JALR/ADD with ex_pr_miss = 1 -> no counter or statistics change.

Source files
------------

// File: rtl/br_pred_if.sv
// Fetch/execute/statistics bundle for the br_pred branch predictor.
// master: pipeline side (drives fetch/execute/stall/flush, observes predictions and stats).
// slave : predictor side.
//   if_valid/if_pc/if_ir        fetch-stage instruction used for lookup
//   stall/flush                 pipeline control
//   pr_taken/pr_addr/pr_valid   registered prediction for the instruction in decode
//   ex_valid/ex_pc/ex_ir        execute-stage instruction used for training
//   ex_pr_taken/ex_pr_miss      travelled prediction and branch-ALU mispredict flag
//   br_cnt/miss_cnt             saturating branch and mispredict statistics
interface br_pred_if #(
    parameter int unsigned CNT_W = 32
);
    logic             if_valid;
    logic [63:0]      if_pc;
    logic [31:0]      if_ir;
    logic             stall;
    logic             flush;
    logic             pr_taken;
    logic [63:0]      pr_addr;
    logic             pr_valid;
    logic             ex_valid;
    logic [63:0]      ex_pc;
    logic [31:0]      ex_ir;
    logic             ex_pr_taken;
    logic             ex_pr_miss;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] miss_cnt;

    modport master (
        output if_valid, if_pc, if_ir, stall, flush,
        output ex_valid, ex_pc, ex_ir, ex_pr_taken, ex_pr_miss,
        input  pr_taken, pr_addr, pr_valid, br_cnt, miss_cnt
    );

    modport slave (
        input  if_valid, if_pc, if_ir, stall, flush,
        input  ex_valid, ex_pc, ex_ir, ex_pr_taken, ex_pr_miss,
        output pr_taken, pr_addr, pr_valid, br_cnt, miss_cnt
    );
endinterface

// File: rtl/br_pred.sv
// Dynamic branch predictor: a table of 2-bit saturating counters indexed by pc[IDX_W+1:2].
// Looks up the fetch PC combinationally and registers pr_taken/pr_addr/pr_valid (1-cycle
// latency); trains on the execute-stage resolution (actual = ex_pr_taken ^ ex_pr_miss).
// Ports:
//   clk    core clock
//   rst_n  asynchronous active-low reset
//   bp_io  br_pred_if slave: fetch/execute inputs, predictions and statistics outputs.
//          The interface's CNT_W must equal this module's CNT_W.
module br_pred #(
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned IDX_W       = $clog2(BHT_ENTRIES),
    parameter int unsigned CNT_W       = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    br_pred_if.slave  bp_io
);
    localparam logic [6:0] OpBranch = 7'b1100011;

    logic [1:0]       cnt_q [BHT_ENTRIES];
    logic [1:0]       cnt_d [BHT_ENTRIES];
    logic             pr_taken_q, pr_taken_d;
    logic             pr_valid_q, pr_valid_d;
    logic [63:0]      pr_addr_q, pr_addr_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    logic             f_br, e_br, actual, taken;
    logic [IDX_W-1:0] f_idx, e_idx;
    logic [1:0]       upd_cnt;
    logic [63:0]      offset, target;

    // Fields of the instructions and PCs that the predictor never looks at.
    logic unused_bits;
    assign unused_bits = ^{bp_io.if_ir[24:12], bp_io.ex_ir[31:7],
                           bp_io.ex_pc[63:IDX_W+2], bp_io.ex_pc[1:0]};

    assign f_br   = bp_io.if_valid && (bp_io.if_ir[6:0] == OpBranch);
    assign f_idx  = bp_io.if_pc[IDX_W+1:2];
    assign e_br   = bp_io.ex_valid && !bp_io.stall && (bp_io.ex_ir[6:0] == OpBranch);
    assign e_idx  = bp_io.ex_pc[IDX_W+1:2];
    assign actual = bp_io.ex_pr_taken ^ bp_io.ex_pr_miss;

    // Saturating counter step for the resolving branch.
    always_comb begin
        upd_cnt = cnt_q[e_idx];
        if (actual && cnt_q[e_idx] != 2'b11) begin
            upd_cnt = cnt_q[e_idx] + 2'd1;
        end else if (!actual && cnt_q[e_idx] != 2'b00) begin
            upd_cnt = cnt_q[e_idx] - 2'd1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (e_br) begin
            cnt_d[e_idx] = upd_cnt;
        end
    end

    // Lookup reads the next-state table so a same-index update is bypassed into it.
    assign taken  = f_br && cnt_d[f_idx][1];
    assign offset = {{51{bp_io.if_ir[31]}}, bp_io.if_ir[31], bp_io.if_ir[7],
                     bp_io.if_ir[30:25], bp_io.if_ir[11:8], 1'b0};
    assign target = taken ? bp_io.if_pc + offset : bp_io.if_pc + 64'd4;

    always_comb begin
        pr_valid_d = pr_valid_q;
        pr_taken_d = pr_taken_q;
        pr_addr_d  = pr_addr_q;
        if (!bp_io.stall) begin
            pr_valid_d = f_br && !bp_io.flush;
            pr_taken_d = taken && !bp_io.flush;
            pr_addr_d  = target;
        end
    end

    always_comb begin
        br_cnt_d   = br_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (e_br && br_cnt_q != '1) begin
            br_cnt_d = br_cnt_q + CNT_W'(1);
        end
        if (e_br && bp_io.ex_pr_miss && miss_cnt_q != '1) begin
            miss_cnt_d = miss_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
                cnt_q[i] <= 2'b01;
            end
            pr_taken_q <= 1'b0;
            pr_valid_q <= 1'b0;
            pr_addr_q  <= '0;
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            pr_taken_q <= pr_taken_d;
            pr_valid_q <= pr_valid_d;
            pr_addr_q  <= pr_addr_d;
            br_cnt_q   <= br_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign bp_io.pr_taken = pr_taken_q;
    assign bp_io.pr_valid = pr_valid_q;
    assign bp_io.pr_addr  = pr_addr_q;
    assign bp_io.br_cnt   = br_cnt_q;
    assign bp_io.miss_cnt = miss_cnt_q;
endmodule

// File: tb/tb_br_pred.sv
// Self-checking bench for br_pred: directed scenarios followed by randomized traffic, all
// checked against a table-of-integers reference model of the predictor's rules.
module tb_br_pred;
    localparam int Entries = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   clk_en = 1'b1;

    br_pred_if #(.CNT_W(32)) bus ();

    br_pred #(.BHT_ENTRIES(64), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp_io (bus)
    );

    always #5 clk = clk_en ? ~clk : 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    // Stimulus for the next cycle, with generator-side knowledge of what it encodes.
    bit          f_valid, f_isbr, stl, fls, e_valid, e_isbr, e_prt, e_miss;
    logic [63:0] f_pc, e_pc;
    logic [31:0] f_ir, e_ir;
    longint      f_imm;

    // Reference model.
    int          ctr [Entries];
    longint      m_br, m_miss;
    bit          x_valid, x_taken, x_addr_known;
    logic [63:0] x_addr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_br(input longint imm, input logic [2:0] f3);
        logic [12:0] im;
        logic [31:0] r;
        im = 13'(imm);
        r  = $urandom();
        return {im[12], im[10:5], r[24:20], r[19:15], f3, im[4:1], im[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] mk_other(input logic [6:0] op);
        logic [31:0] r;
        r = $urandom();
        return {r[31:7], op};
    endfunction

    function automatic int idx_of(input logic [63:0] pc);
        return int'((pc >> 2) % Entries);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < Entries; i++) ctr[i] = 1;
        m_br = 0;
        m_miss = 0;
        x_valid = 0;
        x_taken = 0;
        x_addr = '0;
        x_addr_known = 1;
    endtask

    task automatic set_idle();
        f_valid = 0; f_isbr = 0; f_pc = '0; f_ir = 32'h0000_0013; f_imm = 0;
        stl = 0; fls = 0;
        e_valid = 0; e_isbr = 0; e_pc = '0; e_ir = 32'h0000_0013; e_prt = 0; e_miss = 0;
    endtask

    task automatic fetch_br(input logic [63:0] pc, input longint imm, input logic [2:0] f3);
        f_valid = 1; f_isbr = 1; f_pc = pc; f_imm = imm; f_ir = mk_br(imm, f3);
    endtask

    task automatic exec_br(input logic [63:0] pc, input bit prt, input bit miss);
        e_valid = 1; e_isbr = 1; e_pc = pc; e_ir = mk_br(16, 3'b000); e_prt = prt; e_miss = miss;
    endtask

    // One clock: apply stimulus, advance the model, compare just after the edge.
    task automatic tick();
        int  i;
        bit  fb, tk;
        bus.if_valid = f_valid; bus.if_pc = f_pc; bus.if_ir = f_ir;
        bus.stall = stl; bus.flush = fls;
        bus.ex_valid = e_valid; bus.ex_pc = e_pc; bus.ex_ir = e_ir;
        bus.ex_pr_taken = e_prt; bus.ex_pr_miss = e_miss;
        if (!stl) begin
            // Training happens first so a same-index lookup sees the updated counter.
            if (e_valid && e_isbr) begin
                i = idx_of(e_pc);
                if (e_prt ^ e_miss) ctr[i] = (ctr[i] < 3) ? ctr[i] + 1 : 3;
                else                ctr[i] = (ctr[i] > 0) ? ctr[i] - 1 : 0;
                if (m_br < 64'hFFFF_FFFF) m_br++;
                if (e_miss && m_miss < 64'hFFFF_FFFF) m_miss++;
            end
            fb = f_valid && f_isbr;
            tk = fb && (ctr[idx_of(f_pc)] >= 2);
            x_valid = fb && !fls;
            x_taken = tk && !fls;
            x_addr = tk ? f_pc + 64'(f_imm) : f_pc + 64'd4;
            x_addr_known = !fls;
        end
        @(posedge clk);
        #1;
        chk("pr_valid", 64'(bus.pr_valid), 64'(x_valid));
        chk("pr_taken", 64'(bus.pr_taken), 64'(x_taken));
        if (x_addr_known) chk("pr_addr", bus.pr_addr, x_addr);
        chk("br_cnt", 64'(bus.br_cnt), 64'(m_br));
        chk("miss_cnt", 64'(bus.miss_cnt), 64'(m_miss));
    endtask

    initial begin
        logic [6:0] ops [4];
        logic [63:0] pool_pc;
        ops[0] = 7'b0010011; ops[1] = 7'b0110011; ops[2] = 7'b1100111; ops[3] = 7'b0000011;

        set_idle();
        model_reset();
        rst_n = 0;
        #22 rst_n = 1;
        @(negedge clk);

        // Training at 0x1000: two taken resolutions take 01 -> 11.
        exec_br(64'h1000, 0, 1); tick();
        exec_br(64'h1000, 0, 1); tick();
        set_idle(); fetch_br(64'h1000, 16, 3'b000); tick();
        chk("train_taken", 64'(bus.pr_taken), 64'd1);
        chk("train_addr", bus.pr_addr, 64'h1010);
        set_idle(); exec_br(64'h1000, 1, 1); tick();
        exec_br(64'h1000, 1, 1); tick();
        set_idle(); fetch_br(64'h1000, 16, 3'b000); tick();
        chk("untrain_taken", 64'(bus.pr_taken), 64'd0);
        chk("untrain_addr", bus.pr_addr, 64'h1004);

        // Saturation plus negative offset on BNE at 0x2000.
        set_idle(); exec_br(64'h2000, 0, 1); tick();
        exec_br(64'h2000, 0, 1); tick();
        repeat (3) begin exec_br(64'h2000, 1, 0); tick(); end
        set_idle(); fetch_br(64'h2000, -8, 3'b001); tick();
        chk("sat_taken", 64'(bus.pr_taken), 64'd1);
        chk("sat_addr", bus.pr_addr, 64'h1FF8);
        chk("sat_miss", 64'(bus.miss_cnt), 64'd6);

        // Bring the shared counter back to 01, then bypass a taken update into a lookup.
        set_idle(); exec_br(64'h3000, 1, 1); tick();
        exec_br(64'h3000, 1, 1); tick();
        set_idle(); exec_br(64'h3000, 0, 1); fetch_br(64'h3000, 32, 3'b100); tick();
        chk("bypass_taken", 64'(bus.pr_taken), 64'd1);
        chk("bypass_addr", bus.pr_addr, 64'h3020);

        // Stall holds everything even with updates pending.
        set_idle(); stl = 1; exec_br(64'h3000, 1, 1); fetch_br(64'h4000, 8, 3'b000);
        repeat (3) tick();
        chk("stall_hold_taken", 64'(bus.pr_taken), 64'd1);
        // Flush with a branch in fetch.
        set_idle(); fls = 1; fetch_br(64'h1000, 16, 3'b000); tick();
        chk("flush_valid", 64'(bus.pr_valid), 64'd0);
        set_idle(); fetch_br(64'h2000, -8, 3'b001); tick();
        set_idle(); stl = 1; fls = 1; fetch_br(64'h1000, 16, 3'b000); tick();
        chk("stall_flush_valid", 64'(bus.pr_valid), 64'd1);

        // Non-branch filter.
        set_idle(); f_valid = 1; f_pc = 64'h5000; f_ir = mk_other(7'b0010011); tick();
        chk("addi_valid", 64'(bus.pr_valid), 64'd0);
        chk("addi_addr", bus.pr_addr, 64'h5004);
        set_idle(); e_valid = 1; e_pc = 64'h1000; e_ir = mk_other(7'b1100111); e_miss = 1; tick();
        e_ir = mk_other(7'b0110011); tick();
        set_idle(); fetch_br(64'h1000, 16, 3'b000); tick();

        // Randomized traffic over a small PC pool (with aliasing high bits).
        for (int n = 0; n < 1500; n++) begin
            set_idle();
            pool_pc = 64'($urandom_range(0, 95)) << 2;
            if ($urandom_range(0, 3) == 0) pool_pc = pool_pc | (64'($urandom()) << 12);
            f_valid = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) != 0) begin
                fetch_br(pool_pc, (longint'($urandom_range(0, 4095)) - 2048) * 2,
                         3'($urandom_range(0, 7)));
                f_valid = ($urandom_range(0, 9) != 0);
            end else begin
                f_pc = pool_pc; f_ir = mk_other(ops[$urandom_range(0, 3)]);
            end
            pool_pc = 64'($urandom_range(0, 95)) << 2;
            if ($urandom_range(0, 3) != 0) begin
                exec_br(pool_pc, 1'($urandom()), 1'($urandom()));
            end else begin
                e_pc = pool_pc; e_ir = mk_other(ops[$urandom_range(0, 3)]);
                e_prt = 1'($urandom()); e_miss = 1'($urandom());
            end
            e_valid = ($urandom_range(0, 9) != 0);
            stl = ($urandom_range(0, 9) == 0);
            fls = ($urandom_range(0, 9) == 0);
            tick();
        end

        // Asynchronous reset with the clock stopped.
        clk_en = 0;
        #20;
        rst_n = 0;
        #2;
        chk("rst_pr_taken", 64'(bus.pr_taken), 64'd0);
        chk("rst_pr_valid", 64'(bus.pr_valid), 64'd0);
        chk("rst_pr_addr", bus.pr_addr, 64'd0);
        chk("rst_br_cnt", 64'(bus.br_cnt), 64'd0);
        chk("rst_miss_cnt", 64'(bus.miss_cnt), 64'd0);
        model_reset();
        #5 rst_n = 1;
        #3 clk_en = 1;
        set_idle(); fetch_br(64'h1000, 16, 3'b000); tick();
        chk("post_rst_taken", 64'(bus.pr_taken), 64'd0);
        chk("post_rst_addr", bus.pr_addr, 64'h1004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
